// File: rtl/apb_slave_regfile.sv
// APB3 completer with a NUM_REGS x DATA_W register file, programmable wait states,
// pslverr on misaligned/out-of-range accesses and a one-cycle write notification.
module apb_slave_regfile #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    localparam int               IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_psel,
    input  logic                       i_penable,
    input  logic                       i_pwrite,
    input  logic [ADDR_W-1:0]          i_paddr,
    input  logic [DATA_W-1:0]          i_pwdata,
    output logic [DATA_W-1:0]          o_prdata,
    output logic                       o_pready,
    output logic                       o_pslverr,
    output logic                       o_wr_valid,
    output logic [IDX_W-1:0]           o_wr_addr,
    output logic [DATA_W-1:0]          o_wr_data,
    output logic [NUM_REGS*DATA_W-1:0] o_regs_flat
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          SHIFT     = $clog2(BYTES);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam logic        ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_write, w_write_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_err, w_err_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_pready, w_pready_nxt;
    logic                r_pslverr, w_pslverr_nxt;
    logic [DATA_W-1:0]   r_prdata, w_prdata_nxt;
    logic                w_commit;
    logic                r_wr_valid;
    logic [IDX_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_word;
    logic                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rd;

    // Offset wraps modulo 2^ADDR_W, so addresses below BASE_ADDR land far out of range.
    assign w_off  = i_paddr - BASE_ADDR;
    assign w_word = w_off >> SHIFT;
    assign w_err  = (|(w_off & ADDR_W'(BYTES - 1))) || (w_word >= ADDR_W'(NUM_REGS));
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_rd   = w_err ? '0 : r_regs[w_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_write_nxt   = r_write;
        w_idx_nxt     = r_idx;
        w_err_nxt     = r_err;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = r_pready;
        w_pslverr_nxt = r_pslverr;
        w_prdata_nxt  = r_prdata;
        w_commit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    w_write_nxt   = i_pwrite;
                    w_idx_nxt     = w_idx;
                    w_err_nxt     = w_err;
                    w_cnt_nxt     = WS;
                    w_pready_nxt  = ZERO_WAIT;
                    w_pslverr_nxt = w_err & ZERO_WAIT;
                    w_prdata_nxt  = i_pwrite ? '0 : w_rd;
                    w_state_nxt   = ACCESS;
                end
            end
            ACCESS: begin
                if (!i_psel || !i_penable) begin
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = IDLE;
                end else if (r_pready) begin
                    w_commit      = r_write && !r_err;
                    w_pready_nxt  = 1'b0;
                    w_pslverr_nxt = 1'b0;
                    w_prdata_nxt  = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = r_err;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_write    <= w_write_nxt;
            r_idx      <= w_idx_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pready   <= w_pready_nxt;
            r_pslverr  <= w_pslverr_nxt;
            r_prdata   <= w_prdata_nxt;
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_idx;
                r_wr_data <= i_pwdata;
            end
        end
    end

    // Write data is sampled at the completion edge, not at setup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_idx] <= i_pwdata;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign o_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

    assign o_prdata   = r_prdata;
    assign o_pready   = r_pready;
    assign o_pslverr  = r_pslverr;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 2 wait states) on a shared APB bus
// with per-instance psel; table-driven vectors plus hand-written wait/abort/reset sequences.
module tb_apb_slave_regfile;

    logic         clk;
    logic         rst_n;
    logic         penable;
    logic         pwrite;
    logic [31:0]  paddr;
    logic [31:0]  pwdata;
    logic         psel     [3];
    logic [31:0]  prdata   [3];
    logic         pready   [3];
    logic         pslverr  [3];
    logic         wrValid  [3];
    logic [2:0]   wrAddr   [3];
    logic [31:0]  wrData   [3];
    logic [255:0] regsFlat [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    apb_slave_regfile #(.WAIT_STATES(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel[0]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata[0]), .o_pready(pready[0]),
        .o_pslverr(pslverr[0]), .o_wr_valid(wrValid[0]), .o_wr_addr(wrAddr[0]),
        .o_wr_data(wrData[0]), .o_regs_flat(regsFlat[0]));

    apb_slave_regfile #(.WAIT_STATES(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel[1]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata[1]), .o_pready(pready[1]),
        .o_pslverr(pslverr[1]), .o_wr_valid(wrValid[1]), .o_wr_addr(wrAddr[1]),
        .o_wr_data(wrData[1]), .o_regs_flat(regsFlat[1]));

    apb_slave_regfile #(.WAIT_STATES(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel[2]), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata[2]), .o_pready(pready[2]),
        .o_pslverr(pslverr[2]), .o_wr_valid(wrValid[2]), .o_wr_addr(wrAddr[2]),
        .o_wr_data(wrData[2]), .o_regs_flat(regsFlat[2]));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        expErr;
        logic [31:0] expRdata;
        logic [2:0]  expIdx;
    } vec_t;

    vec_t vecs [12];

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One full transfer; returns after the completion edge, in the wr_valid cycle.
    task automatic applyStimulus(input int inst, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, output logic [31:0] rdata,
                                 output logic err, output int accessCycles);
        @(posedge clk); #1;
        psel[inst] = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = data;
        @(posedge clk); #1;
        penable      = 1'b1;
        accessCycles = 1;
        while (!pready[inst] && accessCycles < 40) begin
            @(posedge clk); #1;
            accessCycles++;
        end
        if (!pready[inst]) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout inst%0d: pready never rose in %0d cycles", inst, accessCycles);
        end
        rdata = prdata[inst];
        err   = pslverr[inst];
        @(posedge clk); #1;
        psel[inst] = 1'b0;
        penable    = 1'b0;
    endtask

    logic [31:0]  rd;
    logic         er;
    int           cyc;
    logic [255:0] model;
    logic         sawHigh;
    logic         sawValid;

    initial begin
        rst_n   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        for (int i = 0; i < 3; i++) psel[i] = 1'b0;

        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         3'd0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF,  1'b0, 32'h0,         3'd1};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hDEADBEEF,  3'd1};
        vecs[3]  = '{1'b1, 32'h0000_001C, 32'h12345678,  1'b0, 32'h0,         3'd7};
        vecs[4]  = '{1'b0, 32'h0000_001C, 32'h0,         1'b0, 32'h12345678,  3'd7};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'hCAFEF00D,  1'b1, 32'h0,         3'd0};
        vecs[6]  = '{1'b1, 32'h0000_0002, 32'hCAFEF00D,  1'b1, 32'h0,         3'd0};
        vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0,         3'd0};
        vecs[8]  = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0,         3'd0};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hA5A5A5A5,  1'b0, 32'h0,         3'd0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5A5A5,  3'd0};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 32'h77777777,  1'b1, 32'h0,         3'd0};

        #12;
        checkOutput("rst_pready",   {255'd0, pready[0]},  256'd0);
        checkOutput("rst_pslverr",  {255'd0, pslverr[0]}, 256'd0);
        checkOutput("rst_prdata",   {224'd0, prdata[0]},  256'd0);
        checkOutput("rst_wrvalid",  {255'd0, wrValid[0]}, 256'd0);
        checkOutput("rst_regs",     regsFlat[0],          256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait instance: every access phase lasts exactly one cycle.
        model = '0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, er, cyc);
            checkOutput($sformatf("v%0d_err", i), {255'd0, er}, {255'd0, vecs[i].expErr});
            checkOutput($sformatf("v%0d_cycles", i), 256'(cyc), 256'd1);
            if (!vecs[i].wr)
                checkOutput($sformatf("v%0d_rdata", i), {224'd0, rd}, {224'd0, vecs[i].expRdata});
            if (vecs[i].wr && !vecs[i].expErr) begin
                model[vecs[i].expIdx*32 +: 32] = vecs[i].data;
                checkOutput($sformatf("v%0d_wrvalid", i), {255'd0, wrValid[0]}, 256'd1);
                checkOutput($sformatf("v%0d_wraddr", i), {253'd0, wrAddr[0]}, {253'd0, vecs[i].expIdx});
                checkOutput($sformatf("v%0d_wrdata", i), {224'd0, wrData[0]}, {224'd0, vecs[i].data});
            end else begin
                checkOutput($sformatf("v%0d_nowrvalid", i), {255'd0, wrValid[0]}, 256'd0);
            end
            checkOutput($sformatf("v%0d_regs", i), regsFlat[0], model);
        end
        @(posedge clk); #1;
        checkOutput("wrvalid_one_cycle", {255'd0, wrValid[0]}, 256'd0);

        // Three wait states: pready on the 4th access cycle.
        applyStimulus(1, 1'b1, 32'h8, 32'h0BB0_1234, rd, er, cyc);
        checkOutput("ws3_wr_cycles", 256'(cyc), 256'd4);
        checkOutput("ws3_wr_valid", {255'd0, wrValid[1]}, 256'd1);
        checkOutput("ws3_wr_regs", regsFlat[1], 256'h0BB0_1234 << 64);
        applyStimulus(1, 1'b0, 32'h8, 32'h0, rd, er, cyc);
        checkOutput("ws3_rd_cycles", 256'(cyc), 256'd4);
        checkOutput("ws3_rd_data", {224'd0, rd}, {224'd0, 32'h0BB0_1234});
        applyStimulus(1, 1'b0, 32'h24, 32'h0, rd, er, cyc);
        checkOutput("ws3_err_cycles", 256'(cyc), 256'd4);
        checkOutput("ws3_err_flag", {255'd0, er}, 256'd1);

        // Two wait states, psel dropped in the first access cycle.
        @(posedge clk); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h1111_2222;
        @(posedge clk); #1;
        psel[2] = 1'b0; penable = 1'b1;
        sawHigh = 1'b0; sawValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            sawHigh  = sawHigh | pready[2];
            sawValid = sawValid | wrValid[2];
        end
        penable = 1'b0;
        checkOutput("abort_pready", {255'd0, sawHigh}, 256'd0);
        checkOutput("abort_wrvalid", {255'd0, sawValid}, 256'd0);
        checkOutput("abort_regs", regsFlat[2], 256'd0);
        applyStimulus(2, 1'b1, 32'h4, 32'h1111_2222, rd, er, cyc);
        checkOutput("ws2_cycles", 256'(cyc), 256'd3);
        checkOutput("ws2_wrvalid", {255'd0, wrValid[2]}, 256'd1);
        checkOutput("ws2_regs", regsFlat[2], 256'h1111_2222 << 32);

        // Protocol violation in IDLE: psel and penable together are ignored.
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0;
        sawHigh = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sawHigh = sawHigh | pready[0];
        end
        psel[0] = 1'b0; penable = 1'b0;
        checkOutput("violation_pready", {255'd0, sawHigh}, 256'd0);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
        checkOutput("violation_recover", {224'd0, rd}, {224'd0, 32'hA5A5A5A5});

        // Reset asserted while the access phase is waiting for its completion edge.
        @(posedge clk); #1;
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1;
        checkOutput("rst_mid_pready_before", {255'd0, pready[0]}, 256'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_pready", {255'd0, pready[0]}, 256'd0);
        checkOutput("rst_mid_regs0", regsFlat[0], 256'd0);
        checkOutput("rst_mid_regs2", regsFlat[2], 256'd0);
        @(posedge clk); #1;
        checkOutput("rst_mid_wrvalid", {255'd0, wrValid[0]}, 256'd0);
        psel[0] = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 32'h8, 32'h0BAD_F00D, rd, er, cyc);
        checkOutput("post_rst_cycles", 256'(cyc), 256'd1);
        checkOutput("post_rst_wraddr", {253'd0, wrAddr[0]}, 256'd2);
        checkOutput("post_rst_regs", regsFlat[0], 256'h0BAD_F00D << 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
